// File: rtl/demux_pkg.sv
// Shared types and constants for the 1-to-4 registered stream dispatcher.
// Optional statistics logic in the top is guarded by DISPATCH_STATS_EN.
package demux_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam int NUM_LANES = 4;
  localparam int SEL_W     = 2;
  localparam int STAT_W    = 8;

  localparam logic MODE_EXPLICIT = 1'b0;
  localparam logic MODE_RR       = 1'b1;

  // One-hot lane mask for a lane index.
  function automatic logic [NUM_LANES-1:0] lane_onehot(input logic [SEL_W-1:0] i_sel);
    logic [NUM_LANES-1:0] v;
    v        = '0;
    v[i_sel] = 1'b1;
    return v;
  endfunction

endpackage : demux_pkg

// File: rtl/demux_dispatch_1to4_rr_pointer.sv
// Modulo-4 round-robin lane pointer with enable and synchronous clear.
module rr_pointer
  import demux_pkg::*;
(
  input  logic             clk,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [SEL_W-1:0] o_ptr
);

  logic [SEL_W-1:0] r_ptr;

  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // pre-edge values, regardless of block ordering in simulation.
  always_ff @(posedge clk) begin
    if (i_clr) begin
      r_ptr <= '0;
    end else if (i_en) begin
      r_ptr <= r_ptr + 1'b1;  // natural 2-bit wrap gives 3 -> 0
    end
  end

  assign o_ptr = r_ptr;

endmodule : rr_pointer

// File: rtl/demux_dispatch_1to4.sv
// One-entry registered dispatcher feeding a 1-to-4 demux (explicit or round-robin lane).
// Define DISPATCH_STATS_EN to add per-lane transfer counters (stat_cnt) and a stall flag.
module demux_dispatch_1to4
  import demux_pkg::*;
#(
  parameter int DATA_W = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DATA_W-1:0]           in_data,
  input  logic [SEL_W-1:0]            in_dest,
  input  logic                        mode,
  output logic [NUM_LANES-1:0]        out_valid,
  input  logic [NUM_LANES-1:0]        out_ready,
  output logic [NUM_LANES*DATA_W-1:0] out_data,
  output logic [SEL_W-1:0]            sel,
  output logic [DATA_W-1:0]           dout,
  output logic                        busy
`ifdef DISPATCH_STATS_EN
  ,
  output logic [NUM_LANES*STAT_W-1:0] stat_cnt,
  output logic                        stall
`endif
);

  state_t                      r_state;
  logic [SEL_W-1:0]            r_sel;
  logic [DATA_W-1:0]           r_dout;
  logic [NUM_LANES-1:0]        r_out_valid;
  logic [NUM_LANES*DATA_W-1:0] r_out_data;

  logic                        w_in_ready;
  logic                        w_accept;
  logic                        w_xfer;
  logic                        w_rr_en;
  logic [SEL_W-1:0]            w_rr_ptr;
  logic [SEL_W-1:0]            w_next_sel;
  logic [NUM_LANES*DATA_W-1:0] w_fan_data;

  // Ready depends only on state and the selected lane's ready, never on in_valid.
  assign w_in_ready = (r_state == IDLE) | out_ready[r_sel];
  assign w_accept   = in_valid & w_in_ready;
  assign w_xfer     = (r_state == HOLD) & out_ready[r_sel];
  assign w_rr_en    = w_accept & (mode == MODE_RR);
  assign w_next_sel = (mode == MODE_RR) ? w_rr_ptr : in_dest;

  rr_pointer u_rr_pointer (
    .clk   (clk),
    .i_clr (rst),
    .i_en  (w_rr_en),
    .o_ptr (w_rr_ptr)
  );

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    w_fan_data                                = '0;
    w_fan_data[w_next_sel*DATA_W +: DATA_W]   = in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_sel       <= '0;
      r_dout      <= '0;
      r_out_valid <= '0;
      r_out_data  <= '0;
    end else begin
      if (w_accept) begin
        // Accept in IDLE, or replace-on-transfer in HOLD: load the new word.
        r_state     <= HOLD;
        r_sel       <= w_next_sel;
        r_dout      <= in_data;
        r_out_valid <= lane_onehot(w_next_sel);
        r_out_data  <= w_fan_data;
      end else if (w_xfer) begin
        // Drained with nothing behind it; sel and dout keep their last values.
        r_state     <= IDLE;
        r_out_valid <= '0;
        r_out_data  <= '0;
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign sel       = r_sel;
  assign dout      = r_dout;
  assign busy      = (r_state == HOLD);

`ifdef DISPATCH_STATS_EN
  logic [NUM_LANES-1:0][STAT_W-1:0] r_stat;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stat <= '0;
    end else if (w_xfer && (r_stat[r_sel] != {STAT_W{1'b1}})) begin
      r_stat[r_sel] <= r_stat[r_sel] + 1'b1;  // saturates at all-ones
    end
  end

  assign stat_cnt = r_stat;
  assign stall    = (r_state == HOLD) & ~out_ready[r_sel];
`endif

endmodule : demux_dispatch_1to4

// File: doc/demux_dispatch_1to4.md
Name: demux_dispatch_1to4

Overview:
- Registered stream dispatcher placed directly upstream of the 1-to-4 demux datapath.
- Accepts a valid/ready input stream and holds each word in a one-entry register.
- Routes the held word to exactly one of four output lanes, chosen by an explicit destination or by a round-robin pointer.
- Also drives a `sel` code, so the combinational 1-to-4 demux can be fed directly from the held word.

Parameters:
- DATA_W, 1, width of one data word; `out_data` lanes are each DATA_W wide.

Ports:
- clk  input  1  sole clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream word is present.
- in_ready  output  1  block can accept a word this cycle.
- in_data  input  DATA_W  word to dispatch.
- in_dest  input  2  explicit destination lane; used only when `mode`=0.
- mode  input  1  0 = explicit destination, 1 = round-robin.
- out_valid  output  4  one-hot; bit k set when lane k holds a word.
- out_ready  input  4  per-lane consumer ready.
- out_data  output  4*DATA_W  lane k occupies bits [k*DATA_W +: DATA_W].
- sel  output  2  lane index of the held word, for the demux select.
- dout  output  DATA_W  held word, for the demux data input.
- busy  output  1  holding register is occupied.

Behaviour:
- States: IDLE (register empty) and HOLD (register full).
- Reset:
  - State goes to IDLE; `out_valid`=0, `out_data`=0, `sel`=0, `dout`=0, `busy`=0.
  - Round-robin pointer `rr_ptr`=0.
  - Reset asserted mid-transfer discards the held word with no output handshake.
- `in_ready` = (state==IDLE) | out_ready[sel]. It is combinational from `out_ready`; there is no combinational path from `in_valid`.
- Accept: in_valid & in_ready. On accept:
  - Latch `in_data` into `dout`.
  - Latch the lane into `sel`: `in_dest` when `mode`=0, `rr_ptr` when `mode`=1.
  - Go to HOLD.
- `mode` and `in_dest` are sampled only on the accept cycle. Changing them while in HOLD has no effect on the held word.
- `rr_ptr` increments modulo 4 (3 -> 0) only on an accept with `mode`=1. In explicit mode it keeps its value.
- Outputs in HOLD:
  - out_valid = 4'b0001 << sel.
  - `out_data` carries `dout` on lane `sel` and zeros on the other three lanes, the same semantics as a 1-to-4 demux.
  - The output is a registered view; latency from input accept to `out_valid` is 1 cycle.
- Output transfer: out_valid[sel] & out_ready[sel]. Ready on any non-selected lane is ignored.
- Simultaneous output transfer and accept in HOLD: the new word replaces the old one and the state stays HOLD. This gives full throughput of 1 word/cycle with no bubble.
- Output transfer with no accept: go to IDLE; `out_valid`, `out_data` and `busy` go to 0. `sel` and `dout` keep their last values.
- Back-pressure: while out_ready[sel]=0 in HOLD, `in_ready`=0 and the held word and `sel` are stable; `out_valid` must never drop before its transfer.
- `busy` = (state==HOLD).

Optional Feature:
- Macro: DISPATCH_STATS_EN.
- Defined:
  - Adds output port `stat_cnt` (32 bits): four 8-bit counters, lane k at [8k +: 8].
  - Each counter increments on an output transfer on its lane and saturates at 255.
  - Counters are cleared by `rst`.
  - Adds output `stall` (1 bit) = HOLD & ~out_ready[sel].
- Undefined: neither port exists and no counter logic is synthesized. All other behaviour is identical.

Decomposition:
- Package `demux_pkg`:
  - state typedef {IDLE, HOLD}
  - NUM_LANES=4, SEL_W=2
  - MODE_EXPLICIT=0, MODE_RR=1
  - STAT_W=8
- One natural sub-module, `rr_pointer`: a 2-bit modulo-4 counter with enable and synchronous clear.
- The combinational lane fan-out stays inline in the top module.

Test Plan:
- Reset with in_valid=1 applied -> `out_valid`=0000, `busy`=0, `in_ready`=1 on the first cycle after reset deasserts; `rr_ptr` read back via `sel` on the next RR accept = 00.
- Explicit mode, DATA_W=1, words {1,1,1,1} with in_dest 0..3, all out_ready=1 -> `out_valid` sequence 0001, 0010, 0100, 1000 on consecutive cycles; lane data=1 only on the selected lane.
- RR mode, 6 back-to-back words, out_ready=1111 -> `sel` = 0,1,2,3,0,1; `in_ready` held 1 throughout (no bubbles).
- Back-pressure: word to lane 2 with out_ready=1011 for 3 cycles -> `out_valid`=0100 stable, `in_ready`=0, `dout` unchanged; then out_ready=1111 -> transfer, next word accepted the same cycle.
- Mode/dest changed during HOLD (in_dest 1->3) -> held word still exits on lane 1; next word goes to lane 3.
- With DISPATCH_STATS_EN, 300 transfers to lane 0 and 5 to lane 3 -> `stat_cnt`=0x050000FF; reset -> 0.
